// File: rtl/ppx_burst_controller.sv
// ppx_burst_controller: sequences a downstream ppx_generator through
// delayed, counted or continuous bursts. Period and duty changes are
// held in a shadow copy and only reach the generator on a period boundary.
module ppx_burst_controller #(
  parameter logic [31:0] CLK_FREQ = 32'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cfg_xcount,
  input  logic [4:0]  cfg_xduty_log2,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_num_pulses,
  input  logic [31:0] cfg_delay,
  input  logic        start,
  input  logic        stop,
  input  logic        ppx_in,
  output logic        gen_reset,
  output logic        gen_en,
  output logic [31:0] gen_xcount,
  output logic [4:0]  gen_xduty_log2,
  output logic        ppx_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] pulse_count
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

  state_t      state_reg, state_next;
  logic        gen_reset_reg, gen_reset_next;
  logic        gen_en_reg, gen_en_next;
  logic [31:0] gen_xcount_reg, gen_xcount_next;
  logic [4:0]  gen_duty_reg, gen_duty_next;
  logic [31:0] shadow_xcount_reg, shadow_xcount_next;
  logic [4:0]  shadow_duty_reg, shadow_duty_next;
  logic        pending_reg, pending_next;
  logic        stop_pending_reg, stop_pending_next;
  logic        done_reg, done_next;
  logic [15:0] pulse_count_reg, pulse_count_next;
  logic [15:0] num_pulses_reg, num_pulses_next;
  logic [31:0] delay_reg, delay_next;
  logic [31:0] delay_cnt_reg, delay_cnt_next;
  logic [31:0] period_cnt_reg, period_cnt_next;
  logic [31:0] eff_period;
  logic        boundary;

  // A zero period means "one second" on the generator side.
  assign eff_period = (gen_xcount_reg == 32'd0) ? CLK_FREQ : gen_xcount_reg;
  // period_cnt tracks the generator's own counter, so this is its wrap cycle.
  assign boundary   = gen_en_reg && (period_cnt_reg == eff_period - 32'd1);

  // Next-state, sequencing and shadow/active configuration handling.
  always_comb begin
    state_next         = state_reg;
    gen_xcount_next    = gen_xcount_reg;
    gen_duty_next      = gen_duty_reg;
    shadow_xcount_next = shadow_xcount_reg;
    shadow_duty_next   = shadow_duty_reg;
    pending_next       = pending_reg;
    stop_pending_next  = stop_pending_reg;
    done_next          = 1'b0;
    pulse_count_next   = pulse_count_reg;
    num_pulses_next    = num_pulses_reg;
    delay_next         = delay_reg;
    delay_cnt_next     = delay_cnt_reg;
    period_cnt_next    = period_cnt_reg;

    if (gen_reset_reg) begin
      period_cnt_next = 32'd0;
    end else if (gen_en_reg) begin
      period_cnt_next = boundary ? 32'd0 : period_cnt_reg + 32'd1;
    end

    // A write always lands in the shadow; the latest one wins.
    if (cfg_wr) begin
      shadow_xcount_next = cfg_xcount;
      shadow_duty_next   = cfg_xduty_log2;
      pending_next       = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          gen_xcount_next  = shadow_xcount_reg;
          gen_duty_next    = shadow_duty_reg;
          pending_next     = cfg_wr;
          num_pulses_next  = cfg_num_pulses;
          delay_next       = cfg_delay;
          delay_cnt_next   = 32'd0;
          pulse_count_next = 16'd0;
          state_next       = (cfg_delay != 32'd0) ? DELAY : RUN;
        end
      end
      DELAY: begin
        if (stop) begin
          state_next = IDLE;
        end else if (delay_cnt_reg == delay_reg - 32'd1) begin
          state_next = RUN;
        end else begin
          delay_cnt_next = delay_cnt_reg + 32'd1;
        end
      end
      RUN: begin
        if (stop) begin
          stop_pending_next = 1'b1;
        end
        if (boundary) begin
          pulse_count_next = pulse_count_reg + 16'd1;
          if (((num_pulses_reg != 16'd0) && (pulse_count_reg + 16'd1 == num_pulses_reg))
              || stop_pending_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (pending_reg && !cfg_wr) begin
            // A write on this very cycle defers the update one more period.
            gen_xcount_next = shadow_xcount_reg;
            gen_duty_next   = shadow_duty_reg;
            pending_next    = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == IDLE) begin
      stop_pending_next = 1'b0;
    end

    // Generator controls follow the state we are about to enter.
    gen_en_next    = (state_next == RUN);
    gen_reset_next = (state_next != RUN);
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      gen_reset_reg     <= 1'b1;
      gen_en_reg        <= 1'b0;
      gen_xcount_reg    <= 32'd0;
      gen_duty_reg      <= 5'd0;
      shadow_xcount_reg <= 32'd0;
      shadow_duty_reg   <= 5'd0;
      pending_reg       <= 1'b0;
      stop_pending_reg  <= 1'b0;
      done_reg          <= 1'b0;
      pulse_count_reg   <= 16'd0;
      num_pulses_reg    <= 16'd0;
      delay_reg         <= 32'd0;
      delay_cnt_reg     <= 32'd0;
      period_cnt_reg    <= 32'd0;
    end else begin
      state_reg         <= state_next;
      gen_reset_reg     <= gen_reset_next;
      gen_en_reg        <= gen_en_next;
      gen_xcount_reg    <= gen_xcount_next;
      gen_duty_reg      <= gen_duty_next;
      shadow_xcount_reg <= shadow_xcount_next;
      shadow_duty_reg   <= shadow_duty_next;
      pending_reg       <= pending_next;
      stop_pending_reg  <= stop_pending_next;
      done_reg          <= done_next;
      pulse_count_reg   <= pulse_count_next;
      num_pulses_reg    <= num_pulses_next;
      delay_reg         <= delay_next;
      delay_cnt_reg     <= delay_cnt_next;
      period_cnt_reg    <= period_cnt_next;
    end
  end

  assign gen_reset      = gen_reset_reg;
  assign gen_en         = gen_en_reg;
  assign gen_xcount     = gen_xcount_reg;
  assign gen_xduty_log2 = gen_duty_reg;
  assign ppx_out        = ppx_in & gen_en_reg;
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign pulse_count    = pulse_count_reg;

endmodule

// File: tb/tb_ppx_burst_controller.sv
// Testbench for ppx_burst_controller: directed scenarios plus a long
// randomized run, every cycle compared against a burst-level reference model.
module tb_ppx_burst_controller;

  localparam int unsigned TB_CLK = 16;

  logic        clk = 1'b0;
  logic        reset, cfg_wr, start, stop, ppx_in;
  logic [31:0] cfg_xcount, cfg_delay;
  logic [4:0]  cfg_xduty_log2;
  logic [15:0] cfg_num_pulses;
  logic        gen_reset, gen_en, ppx_out, busy, done;
  logic [31:0] gen_xcount;
  logic [4:0]  gen_xduty_log2;
  logic [15:0] pulse_count;

  ppx_burst_controller #(.CLK_FREQ(32'd16)) dut (
    .clk(clk), .reset(reset), .cfg_xcount(cfg_xcount), .cfg_xduty_log2(cfg_xduty_log2),
    .cfg_wr(cfg_wr), .cfg_num_pulses(cfg_num_pulses), .cfg_delay(cfg_delay),
    .start(start), .stop(stop), .ppx_in(ppx_in), .gen_reset(gen_reset), .gen_en(gen_en),
    .gen_xcount(gen_xcount), .gen_xduty_log2(gen_xduty_log2), .ppx_out(ppx_out),
    .busy(busy), .done(done), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Requested configuration values presented on the cfg_* inputs.
  logic [31:0] c_x  = 0;
  logic [4:0]  c_d  = 0;
  logic [15:0] c_n  = 0;
  logic [31:0] c_dl = 0;

  // Reference model: mode 0 idle, 1 waiting out the delay, 2 running periods.
  int          m_mode;
  logic [31:0] m_x, m_sh_x, m_left;
  logic [4:0]  m_d, m_sh_d;
  logic [15:0] m_num, m_pc;
  int unsigned m_pos;
  bit          m_pending, m_stop_req, m_done;

  // Observation bookkeeping for directed scenarios.
  int step_idx, en_cycles, first_en, done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_d = 0; m_sh_x = 0; m_sh_d = 0; m_left = 0;
    m_num = 0; m_pc = 0; m_pos = 0; m_pending = 0; m_stop_req = 0; m_done = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input bit r, input bit w, input bit s, input bit sp);
    int unsigned p;
    bit          last;
    @(negedge clk);
    reset = r; cfg_wr = w; start = s; stop = sp; ppx_in = 1'($urandom);
    cfg_xcount = c_x; cfg_xduty_log2 = c_d; cfg_num_pulses = c_n; cfg_delay = c_dl;
    #1;
    check("gen_reset", 32'(gen_reset), 32'(m_mode != 2));
    check("gen_en", 32'(gen_en), 32'(m_mode == 2));
    check("gen_xcount", gen_xcount, m_x);
    check("gen_duty", 32'(gen_xduty_log2), 32'(m_d));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("done", 32'(done), 32'(m_done));
    check("pulse_count", 32'(pulse_count), 32'(m_pc));
    check("ppx_out", 32'(ppx_out), 32'(ppx_in && (m_mode == 2)));
    if (gen_en) begin
      if (en_cycles == 0) first_en = step_idx;
      en_cycles++;
    end
    if (done) done_seen++;
    step_idx++;

    if (r) begin
      model_reset();
      return;
    end
    p = (m_x == 0) ? TB_CLK : m_x;
    m_done = 0;
    if (m_mode == 0) begin
      if (s) begin
        m_x = m_sh_x; m_d = m_sh_d; m_pending = 0;
        m_num = c_n; m_left = c_dl; m_pc = 0; m_pos = 0;
        m_mode = (c_dl != 0) ? 1 : 2;
      end
    end else if (m_mode == 1) begin
      if (sp) m_mode = 0;
      else if (m_left == 1) begin m_mode = 2; m_pos = 0; end
      else m_left--;
    end else begin
      if (m_pos + 1 == p) begin
        m_pc++;
        last = (m_num != 0) && (m_pc == m_num);
        if (last || m_stop_req) begin
          m_mode = 0; m_done = 1;
          $display("[%0t] burst done: pulses=%0d stopped=%0d", $time, m_pc, m_stop_req);
        end else begin
          if (m_pending && !w) begin m_x = m_sh_x; m_d = m_sh_d; m_pending = 0; end
          m_pos = 0;
        end
      end else begin
        m_pos++;
      end
      if (sp) m_stop_req = 1;
    end
    if (m_mode == 0) m_stop_req = 0;
    if (w) begin m_sh_x = c_x; m_sh_d = c_d; m_pending = 1; end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic clear_obs();
    step_idx = 0; en_cycles = 0; first_en = -1; done_seen = 0;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    tick(1);
  endtask

  initial begin
    model_reset();
    reset = 1; cfg_wr = 0; start = 0; stop = 0; ppx_in = 0;
    cfg_xcount = 0; cfg_xduty_log2 = 0; cfg_num_pulses = 0; cfg_delay = 0;
    clear_obs();
    do_reset();
    check("reset_gen_reset", 32'(gen_reset), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);

    // Scenario 1: three 10-cycle periods, no delay.
    c_x = 10; c_d = 0; c_n = 3; c_dl = 0;
    step(0, 1, 0, 0);
    clear_obs(); step(0, 0, 1, 0); tick(40);
    check("s1_en_cycles", en_cycles, 30);
    check("s1_done_count", done_seen, 1);
    check("s1_pulse_count", 32'(pulse_count), 32'd3);
    check("s1_gen_reset_after", 32'(gen_reset), 32'd1);
    $display("scenario 1: en_cycles=%0d done=%0d", en_cycles, done_seen);

    // Scenario 2: delayed single burst, then stop during the delay.
    c_x = 4; c_n = 1; c_dl = 5;
    step(0, 1, 0, 0);
    clear_obs(); step(0, 0, 1, 0); tick(20);
    check("s2_first_en", first_en, 6);
    check("s2_en_cycles", en_cycles, 4);
    check("s2_done_count", done_seen, 1);
    clear_obs(); step(0, 0, 1, 0); tick(2); step(0, 0, 0, 1); tick(10);
    check("s2_abort_en", en_cycles, 0);
    check("s2_abort_done", done_seen, 0);
    check("s2_abort_busy", 32'(busy), 32'd0);
    $display("scenario 2: first_en=%0d abort ok", first_en);

    // Scenario 3: continuous, mid-period update and boundary-coincident update.
    do_reset();
    c_x = 8; c_n = 0; c_dl = 0;
    step(0, 1, 0, 0);
    clear_obs(); step(0, 0, 1, 0); tick(2);
    c_x = 4; step(0, 1, 0, 0); tick(4);
    tick(1); check("s3_old_period", gen_xcount, 32'd8);
    tick(1); check("s3_new_period", gen_xcount, 32'd4);
    tick(2);
    c_x = 6; step(0, 1, 0, 0); check("s3_wr_on_boundary", gen_xcount, 32'd4);
    tick(4); check("s3_deferred_hold", gen_xcount, 32'd4);
    tick(1); check("s3_deferred_apply", gen_xcount, 32'd6);
    step(0, 0, 0, 1); tick(10);
    $display("scenario 3: continuous reconfiguration done");

    // Scenario 4: graceful stop mid-period.
    do_reset();
    c_x = 6; c_d = 1; c_n = 0;
    step(0, 1, 0, 0);
    clear_obs(); step(0, 0, 1, 0); tick(2); step(0, 0, 0, 1); tick(8);
    check("s4_en_cycles", en_cycles, 6);
    check("s4_done_count", done_seen, 1);
    check("s4_pulse_count", 32'(pulse_count), 32'd1);
    $display("scenario 4: stop completed period");

    // Scenario 5: start ignored while running, then reset mid-run.
    do_reset();
    c_x = 5; c_d = 0; c_n = 0;
    step(0, 1, 0, 0);
    clear_obs(); step(0, 0, 1, 0); tick(11); step(0, 0, 1, 0); tick(4);
    check("s5_ignored_start", 32'(pulse_count), 32'd3);
    step(1, 0, 0, 0); tick(1);
    check("s5_gen_reset", 32'(gen_reset), 32'd1);
    check("s5_gen_en", 32'(gen_en), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_pulse_count", 32'(pulse_count), 32'd0);
    check("s5_done", 32'(done), 32'd0);
    $display("scenario 5: mid-run reset");

    // Scenario 6: zero xcount falls back to CLK_FREQ; stop on final boundary.
    c_x = 0; c_n = 2;
    step(0, 1, 0, 0);
    clear_obs(); step(0, 0, 1, 0); tick(31); step(0, 0, 0, 1); tick(5);
    check("s6_en_cycles", en_cycles, 32);
    check("s6_done_count", done_seen, 1);
    check("s6_pulse_count", 32'(pulse_count), 32'd2);
    $display("scenario 6: default period bursts");

    // Randomized run against the reference model.
    for (int i = 0; i < 15000; i++) begin
      bit r, w, s, sp;
      c_x  = $urandom_range(0, 12);
      c_d  = 5'($urandom);
      c_n  = 16'($urandom_range(0, 5));
      c_dl = $urandom_range(0, 6);
      r  = ($urandom_range(0, 699) == 0);
      s  = ($urandom_range(0, 7) == 0);
      w  = !s && ($urandom_range(0, 14) == 0);
      sp = ($urandom_range(0, 39) == 0);
      step(r, w, s, sp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
